// File: rtl/s2p_pkg.sv
// s2p_pkg: shared FSM state encodings, WIDTH limits and count-width helper for serial_to_parallel_chain
package s2p_pkg;
    typedef enum logic {S2P_IDLE = 1'b0, S2P_SHIFT = 1'b1} s2p_state_e;
    localparam int S2P_WIDTH_MIN = 2;
    localparam int S2P_WIDTH_MAX = 32;
    function automatic int s2p_cnt_w(input int frame);
        return $clog2(frame + 1);
    endfunction
endpackage

// File: rtl/serial_to_parallel_chain_if.sv
// serial_to_parallel_chain_if: serial input and valid/ready word output bundle
interface serial_to_parallel_chain_if #(
    parameter int WIDTH = 8
);
    logic             in_bit;
    logic             in_valid;
    logic             in_start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             parity_err;
    modport master (output in_bit, in_valid, in_start, out_ready,
                    input  out_data, out_valid, overrun, parity_err);
    modport slave  (input  in_bit, in_valid, in_start, out_ready,
                    output out_data, out_valid, overrun, parity_err);
endinterface

// File: rtl/s2p_out_buffer.sv
// s2p_out_buffer: one-entry valid/ready holding register for assembled words
module s2p_out_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             perr_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             full_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, perr_q, perr_d, take;
    // accept a word when empty or draining this cycle; otherwise hold
    always_comb begin
        take    = load_i && (!valid_q || ready_i);
        data_d  = take ? data_i : data_q;
        perr_d  = take ? perr_i : perr_q;
        valid_d = take || (valid_q && !ready_i);
    end
    // buffer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign perr_o  = perr_q;
    assign full_o  = valid_q;
endmodule

// File: rtl/serial_to_parallel_chain.sv
// serial_to_parallel_chain: LSB-first serial-to-word deserializer with start-strobe framing; optional parity via S2P_PARITY_EN
module serial_to_parallel_chain
    import s2p_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    serial_to_parallel_chain_if.slave bus
);
`ifdef S2P_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = s2p_cnt_w(FRAME);

    if (WIDTH < S2P_WIDTH_MIN || WIDTH > S2P_WIDTH_MAX) begin : g_width_chk
        $error("WIDTH out of range");
    end

    s2p_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [FRAME-2:0] sh_q, sh_d;
    logic [FRAME-1:0] word;
    logic             done, full, perr, ovr_q, ovr_d;

    assign word = {bus.in_bit, sh_q};
`ifdef S2P_PARITY_EN
    assign perr = ^word;
`else
    assign perr = 1'b0;
`endif

    // framing FSM: start strobe (re)aligns, final bit completes the word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        done    = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_start) begin
                state_d = S2P_SHIFT;
                cnt_d   = CW'(1);
                sh_d    = (FRAME-1)'(bus.in_bit);
            end else if (state_q == S2P_SHIFT) begin
                if (cnt_q == CW'(FRAME - 1)) begin
                    done    = 1'b1;
                    state_d = S2P_IDLE;
                    cnt_d   = '0;
                end else begin
                    sh_d  = sh_q | ((FRAME-1)'(bus.in_bit) << cnt_q);
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        ovr_d = done && full && !bus.out_ready;
    end

    // state, count, shift and overrun registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S2P_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.overrun = ovr_q;

    s2p_out_buffer #(.WIDTH(WIDTH)) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (done),
        .data_i  (word[WIDTH-1:0]),
        .perr_i  (perr),
        .ready_i (bus.out_ready),
        .data_o  (bus.out_data),
        .valid_o (bus.out_valid),
        .perr_o  (bus.parity_err),
        .full_o  (full)
    );
endmodule

// File: tb/tb_serial_to_parallel_chain.sv
// tb_serial_to_parallel_chain: table, directed and random checks of serial_to_parallel_chain
module tb_serial_to_parallel_chain;
`ifdef S2P_PARITY_EN
    localparam int FRAME = 9;
    localparam bit PE = 1'b1;
`else
    localparam int FRAME = 8;
    localparam bit PE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    serial_to_parallel_chain_if #(.WIDTH(8)) bus ();

    serial_to_parallel_chain #(.WIDTH(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] gaps;
        logic       flip;
        logic [7:0] exp_d;
        logic       exp_p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bitx(input logic b, input logic s);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_start = s;
        step();
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] gaps, input logic flip);
        logic b;
        for (int i = 0; i < FRAME; i++) begin
            b = (i < 8) ? d[i] : (^d ^ flip);
            bitx(b, i == 0);
            if (i < 8 && i != FRAME - 1 && gaps[i]) step();
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] d, input logic o, input logic p);
        chk({name, ".valid"}, bus.out_valid, v);
        chk({name, ".data"}, bus.out_data, d);
        chk({name, ".overrun"}, bus.overrun, o);
        chk({name, ".perr"}, bus.parity_err, p);
    endtask

    vec_t vecs[6];
    int bits[$];
    bit act, mv, mp, mo, comp;
    logic [7:0] md;
    int w;

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 8'h55, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFF, PE};
        vecs[4] = '{8'h07, 8'h80, 1'b1, 8'h07, PE};
        vecs[5] = '{8'h81, 8'h0F, 1'b0, 8'h81, 1'b0};
        bus.in_bit = 0; bus.in_valid = 0; bus.in_start = 0; bus.out_ready = 1;
        #12;
        chk_out("reset", 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        step();
        // basic A5
        send(8'hA5, 8'h00, 1'b0);
        chk_out("basic", 1, 8'hA5, 0, 0);
        step();
        chk("basic.one_wide", bus.out_valid, 0);
        // gaps and backpressure
        bus.out_ready = 0;
        send(8'h3C, 8'h7F, 1'b0);
        chk_out("gaps", 1, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("hold", 1, 8'h3C, 0, 0);
        end
        bus.out_ready = 1;
        step();
        chk("bp.clear", bus.out_valid, 0);
        // overrun
        bus.out_ready = 0;
        send(8'h11, 8'h00, 1'b0);
        send(8'h22, 8'h00, 1'b0);
        chk_out("overrun", 1, 8'h11, 1, 0);
        step();
        chk_out("overrun.pulse", 1, 8'h11, 0, 0);
        bus.out_ready = 1;
        step();
        chk("overrun.drain", bus.out_valid, 0);
        step();
        chk("overrun.nomore", bus.out_valid, 0);
        // resync
        bitx(1, 1);
        for (int i = 0; i < 4; i++) bitx(1, 0);
        chk("resync.partial", bus.out_valid, 0);
        send(8'hF0, 8'h00, 1'b0);
        chk_out("resync", 1, 8'hF0, 0, 0);
        step();
        chk("resync.after", bus.out_valid, 0);
        // reset mid-word
        bus.out_ready = 0;
        send(8'h77, 8'h00, 1'b0);
        bitx(1, 1);
        for (int i = 0; i < 3; i++) bitx(0, 0);
        chk("pre_rst.valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, 8'h00, 0, 0);
        #1 rst_n = 1'b1;
        step();
        bus.out_ready = 1;
        send(8'h5A, 8'h00, 1'b0);
        chk_out("post_rst", 1, 8'h5A, 0, 0);
        step();
        // parity
`ifdef S2P_PARITY_EN
        send(8'h07, 8'h00, 1'b0);
        chk_out("par.good", 1, 8'h07, 0, 0);
        step();
        send(8'h07, 8'h00, 1'b1);
        chk_out("par.bad", 1, 8'h07, 0, 1);
        step();
`else
        send(8'h07, 8'h00, 1'b0);
        chk_out("nopar", 1, 8'h07, 0, 0);
        step();
`endif
        // table vectors
        foreach (vecs[k]) begin
            send(vecs[k].d, vecs[k].gaps, vecs[k].flip);
            chk_out($sformatf("vec%0d", k), 1, vecs[k].exp_d, 0, vecs[k].exp_p);
            step();
            chk($sformatf("vec%0d.clear", k), bus.out_valid, 0);
        end
        // random against a frame/queue reference model
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        act = 0; mv = 0; mp = 0; md = 8'h00; bits.delete();
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_start  = ($urandom % 12) == 0;
            bus.in_bit    = $urandom % 2;
            bus.out_ready = ($urandom % 3) != 0;
            comp = 0; mo = 0; w = 0;
            if (bus.in_valid) begin
                if (bus.in_start) begin
                    bits.delete();
                    bits.push_back(int'(bus.in_bit));
                    act = 1;
                end else if (act) begin
                    bits.push_back(int'(bus.in_bit));
                    if (bits.size() == FRAME) begin
                        foreach (bits[i]) w += bits[i] << i;
                        bits.delete();
                        act = 0;
                        comp = 1;
                    end
                end
            end
            if (comp && mv && !bus.out_ready) mo = 1;
            else if (comp) begin
                mv = 1;
                md = w[7:0];
                mp = PE ? ^w[FRAME-1:0] : 1'b0;
            end else if (mv && bus.out_ready) mv = 0;
            step();
            chk_out("rand", mv, md, mo, mp);
        end
        bus.in_valid = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
